neonfox_int_ctrl: RTL and testbench
===================================

// Module: neonfox_int_ctrl
// PURPOSE
//  Parametrised multi-channel interrupt controller for NeonFox-based systems; successor to the core's
//  single-line int_rq/int_addr interrupt scheme. Synchronises NUM_CH request lines, latches edge/level
//  requests, masks and prioritises them, and drives the core's int_rq/int_addr with a held request.
//  Release is by an explicit end-of-interrupt (EOI) write on the IO bus, mapped as a peripheral.
// PARAMETERS
//  NUM_CH      16  number of request channels, 1..16 (registers are 16 bit)
//  ADDR_W      4   width of int_addr; NUM_CH <= 2**ADDR_W
//  SYNC_STAGES 2   flops in each irq_in synchroniser, >= 2
//  GAP_CYCLES  1   int_rq low cycles after EOI before next request, >= 1
// PORTS
//  clk       in   1        core clock; one clock domain
//  reset     in   1        synchronous, active-high
//  irq_in    in   NUM_CH   asynchronous request lines, active-high
//  cfg_addr  in   3        register select
//  cfg_wren  in   1        register write strobe (one cycle = one write)
//  cfg_ren   in   1        register read strobe
//  cfg_wdata in   16       write data
//  cfg_rdata out  16       read data, registered
//  int_rq    out  1        to core int_rq; held high for whole service
//  int_addr  out  ADDR_W   to core int_addr; channel index, stable while int_rq high
// BEHAVIOUR
//  Reset: int_rq=0, int_addr=0, cfg_rdata=0, MASK=0, MODE=0, pending=0, sync/edge flops=0, state=IDLE.
//  Reset mid-service drops int_rq the next cycle; no EOI needed.
//  Registers (cfg_addr): 0 MASK RW (1=enabled); 1 MODE RW (1=edge, 0=level); 2 PENDING R, write-1-clear;
//   3 STATUS R {busy[15], gap[14], 0, vector[ADDR_W-1:0]}; 4 EOI W (any data); 5..7 read 0, writes ignored.
//  Bits >= NUM_CH read 0 and ignore writes. cfg_rdata updates the cycle after cfg_ren, else holds.
//  Pending: edge channel bit set on a synchronised 0->1 transition, cleared by W1C or on acceptance.
//   Level channel bit = synchronised level, not stored; W1C has no effect.
//   Edge set and W1C clear in the same cycle: set wins.
//   Masked channels still latch pending; unmasking later raises the request.
//  Arbitration: eligible = pending & MASK; lowest index wins; fixed priority, no rotation.
//  FSM:
//   IDLE -> REQ when eligible != 0. On that edge: int_addr <= winner, int_rq <= 1;
//    if winner is edge mode, its pending bit clears.
//   REQ: int_rq=1, int_addr frozen. MASK/MODE/irq changes do not affect the current request.
//    Edges still latch. EOI write -> GAP.
//   GAP: int_rq=0 for GAP_CYCLES cycles (core needs a low to re-arm its edge detector), then IDLE.
//   EOI write in IDLE or GAP is ignored.
//  Latency: irq_in high before clk edge 0 -> int_rq high after edge SYNC_STAGES+2 (masked, idle).
//   EOI write at edge k -> int_rq low after edge k+1. Earliest re-request after edge k+1+GAP_CYCLES.
//  Level channel still high after EOI is re-requested after GAP; this is intended.
//  Edge pulses shorter than one clk period may be lost; irq_in must hold >= 2 clk periods.
// TESTING
//  1 Reset; MASK=0x0001, MODE=0x0001; pulse irq_in[0] for 3 cycles -> int_rq=1 at edge 4, int_addr=0,
//    PENDING reads 0x0000.
//  2 MASK=0xFFFF, MODE=0xFFFF; irq_in[5] and [9] rise together -> int_addr=5; EOI -> int_rq 0 for 1 cycle,
//    then int_addr=9.
//  3 Level channel 3 (MODE=0), held high -> after EOI, int_rq re-asserts with int_addr=3 after GAP;
//    drop irq_in[3] then EOI -> stays IDLE.
//  4 MASK=0; edge on ch 7 -> PENDING=0x0080, int_rq=0; W1C 0x0080 same cycle as a new edge on ch 7
//    -> PENDING=0x0080; MASK=0x0080 -> int_addr=7.
//  5 During REQ (int_addr=2): set MASK=0 and raise irq on ch 1 -> int_addr stays 2; EOI in IDLE -> no effect.
//  6 Assert reset while int_rq=1 -> int_rq=0, all registers read 0 next cycle.

Source files
------------

// File: rtl/neonfox_int_ctrl.sv
// NeonFox multi-channel interrupt controller: synchronises, latches, masks and prioritises
// request lines and holds int_rq/int_addr until an EOI write on the config bus.
module neonfox_int_ctrl #(
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [2:0]        cfg_addr,
  input  logic              cfg_wren,
  input  logic              cfg_ren,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              int_rq,
  output logic [ADDR_W-1:0] int_addr
);

  localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_CH) - 32'd1);
  localparam int unsigned GW      = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] dly_q;
  logic [NUM_CH-1:0] prev_q;

  logic [15:0] mask_q;
  logic [15:0] mode_q;
  logic [15:0] pend_q;
  logic [15:0] lvl;
  logic [15:0] rise;
  logic [15:0] pend_vis;
  logic [15:0] eligible;
  logic [15:0] w1c;
  logic [15:0] acc_clr;
  logic [15:0] status;
  logic [15:0] rd_mux;

  logic [3:0]  win_idx;
  logic        hit;
  logic        accept;
  logic        eoi;
  logic        wr_mask;
  logic        wr_mode;
  logic        wr_pend;

  state_t      state_q;
  state_t      state_d;
  logic [GW-1:0] gap_cnt;
  logic        gap_done;

  // One extra stage after the synchroniser gives a registered edge detector (dly vs prev).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q  <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q  <= sync_q[SYNC_STAGES-1];
      prev_q <= dly_q;
    end
  end

  assign lvl  = 16'(dly_q);
  assign rise = 16'(dly_q & ~prev_q);

  // Edge channels come from the latch, level channels straight from the synchronised line.
  assign pend_vis = (pend_q & mode_q) | (lvl & ~mode_q & CH_MASK);
  assign eligible = pend_vis & mask_q;

  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (eligible[i] && !hit) begin
        hit     = 1'b1;
        win_idx = 4'(i);
      end
    end
  end

  assign eoi     = cfg_wren && (cfg_addr == 3'd4);
  assign wr_mask = cfg_wren && (cfg_addr == 3'd0);
  assign wr_mode = cfg_wren && (cfg_addr == 3'd1);
  assign wr_pend = cfg_wren && (cfg_addr == 3'd2);

  assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));

  // Leaving GAP goes straight to REQ when something is eligible, so int_rq is low exactly GAP_CYCLES.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (eoi) state_d = GAP;
      end
      GAP: begin
        if (gap_done) begin
          if (hit) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gap_cnt  <= '0;
      int_rq   <= 1'b0;
      int_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GAP && state_d == GAP) gap_cnt <= gap_cnt + GW'(1);
      else                                  gap_cnt <= '0;
      int_rq <= (state_d == REQ);
      if (accept) int_addr <= ADDR_W'(win_idx);
    end
  end

  assign w1c     = wr_pend ? (cfg_wdata & CH_MASK) : '0;
  assign acc_clr = accept ? (16'd1 << win_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~w1c & ~acc_clr) | rise) & mode_q & CH_MASK;
      if (wr_mask) mask_q <= cfg_wdata & CH_MASK;
      if (wr_mode) mode_q <= cfg_wdata & CH_MASK;
    end
  end

  assign status = {state_q == REQ, state_q == GAP, 14'(int_addr)};

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      3'd0:    rd_mux = mask_q;
      3'd1:    rd_mux = mode_q;
      3'd2:    rd_mux = pend_vis;
      3'd3:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        cfg_rdata <= '0;
    else if (cfg_ren) cfg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_neonfox_int_ctrl.sv
// Bench for neonfox_int_ctrl: directed scenarios then random traffic, every cycle compared
// against a cycle-level behavioural model of the controller.
module tb_neonfox_int_ctrl;

  localparam int S   = 2;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irq_in = '0;
  logic [2:0]  cfg_addr = '0;
  logic        cfg_wren = 1'b0;
  logic        cfg_ren = 1'b0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic        int_rq;
  logic [3:0]  int_addr;

  int total = 0;
  int bad   = 0;

  neonfox_int_ctrl #(
    .NUM_CH(16),
    .ADDR_W(4),
    .SYNC_STAGES(S),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .cfg_addr(cfg_addr),
    .cfg_wren(cfg_wren),
    .cfg_ren(cfg_ren),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .int_rq(int_rq),
    .int_addr(int_addr)
  );

  always #5 clk = ~clk;

  // Model state: a request line sampled at edge t is visible to the controller S+1 edges later.
  bit [15:0] hist [8];
  bit [15:0] m_mask, m_mode, m_edge_pend, m_rdata;
  bit        m_rq;
  int        m_gap;
  int        m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit [15:0] seen, rose, visible, elig, rd;
    int win;
    if (reset) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      m_mask = '0; m_mode = '0; m_edge_pend = '0; m_rdata = '0;
      m_rq = 1'b0; m_gap = 0; m_vec = 0;
      return;
    end
    seen    = hist[S];
    rose    = hist[S] & ~hist[S+1];
    visible = (m_edge_pend & m_mode) | (seen & ~m_mode);
    elig    = visible & m_mask;
    win = -1;
    for (int i = 0; i < 16; i++) if (elig[i] && win < 0) win = i;

    case (cfg_addr)
      3'd0: rd = m_mask;
      3'd1: rd = m_mode;
      3'd2: rd = visible;
      3'd3: rd = {m_rq, (m_gap > 0), 10'd0, 4'(m_vec)};
      default: rd = '0;
    endcase
    if (cfg_ren) m_rdata = rd;

    begin
      bit take = 1'b0;
      if (m_rq) begin
        if (cfg_wren && cfg_addr == 3'd4) begin
          m_rq  = 1'b0;
          m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && win >= 0) take = 1'b1;
      end else if (win >= 0) begin
        take = 1'b1;
      end
      if (cfg_wren && cfg_addr == 3'd2) m_edge_pend &= ~cfg_wdata;
      if (take) begin
        m_rq  = 1'b1;
        m_vec = win;
        m_edge_pend[win] = 1'b0;
      end
      m_edge_pend = (m_edge_pend | rose) & m_mode;
    end
    if (cfg_wren && cfg_addr == 3'd0) m_mask = cfg_wdata;
    if (cfg_wren && cfg_addr == 3'd1) m_mode = cfg_wdata;

    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("int_rq", int_rq, m_rq);
    chk("int_addr", int_addr, m_vec);
    chk("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_wren = 1'b1;
    tick();
    cfg_wren = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    cfg_addr = a; cfg_ren = 1'b1;
    tick();
    cfg_ren = 1'b0;
    chk(tag, cfg_rdata, exp);
  endtask

  initial begin
    // 1: reset, single edge channel, latency and pending cleared on acceptance
    ticks(2);
    chk("rst_rq", int_rq, 0);
    chk("rst_addr", int_addr, 0);
    chk("rst_rdata", cfg_rdata, 0);
    reset = 1'b0;
    wr(3'd0, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    ticks(3);
    irq_in[0] = 1'b0;
    tick();
    chk("t1_rq_early", int_rq, 0);
    tick();
    chk("t1_rq", int_rq, 1);
    chk("t1_addr", int_addr, 0);
    rd_chk("t1_pend", 3'd2, 16'h0000);
    wr(3'd4, 16'h0000);
    ticks(3);

    // 2: priority between two simultaneous edges, one-cycle gap
    wr(3'd0, 16'hFFFF);
    wr(3'd1, 16'hFFFF);
    irq_in[5] = 1'b1; irq_in[9] = 1'b1;
    ticks(5);
    chk("t2_rq", int_rq, 1);
    chk("t2_addr5", int_addr, 5);
    wr(3'd4, 16'h1234);
    chk("t2_gap", int_rq, 0);
    tick();
    chk("t2_rq9", int_rq, 1);
    chk("t2_addr9", int_addr, 9);
    irq_in = '0;
    wr(3'd4, 16'h0000);
    ticks(4);

    // 3: level channel re-requests after gap, then drops
    wr(3'd1, 16'h0000);
    wr(3'd0, 16'h0008);
    irq_in[3] = 1'b1;
    ticks(4);
    chk("t3_rq", int_rq, 1);
    chk("t3_addr", int_addr, 3);
    wr(3'd4, 16'h0000);
    chk("t3_gap", int_rq, 0);
    tick();
    chk("t3_rerq", int_rq, 1);
    chk("t3_readdr", int_addr, 3);
    irq_in[3] = 1'b0;
    ticks(3);
    wr(3'd4, 16'h0000);
    ticks(2);
    chk("t3_idle", int_rq, 0);

    // 4: masked latch, set beats W1C in the same cycle, unmask raises request
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0080);
    irq_in[7] = 1'b1;
    ticks(6);
    rd_chk("t4_pend", 3'd2, 16'h0080);
    chk("t4_rq", int_rq, 0);
    irq_in[7] = 1'b0;
    ticks(3);
    irq_in[7] = 1'b1;
    ticks(3);
    wr(3'd2, 16'h0080);
    rd_chk("t4_pend_setwins", 3'd2, 16'h0080);
    wr(3'd0, 16'h0080);
    tick();
    chk("t4_rq7", int_rq, 1);
    chk("t4_addr7", int_addr, 7);
    irq_in = '0;
    wr(3'd4, 16'h0000);
    ticks(4);

    // 5: request frozen against mask/irq changes; EOI in IDLE ignored
    wr(3'd0, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    ticks(5);
    chk("t5_addr2", int_addr, 2);
    wr(3'd0, 16'h0000);
    irq_in[1] = 1'b1;
    ticks(5);
    chk("t5_hold_rq", int_rq, 1);
    chk("t5_hold_addr", int_addr, 2);
    wr(3'd4, 16'h0000);
    ticks(2);
    wr(3'd4, 16'h0000);
    chk("t5_idle_eoi", int_rq, 0);
    rd_chk("t5_status", 3'd3, 16'h0002);

    // 6: reset mid-service
    wr(3'd0, 16'h0002);
    tick();
    chk("t6_rq", int_rq, 1);
    chk("t6_addr", int_addr, 1);
    reset = 1'b1; irq_in = '0;
    tick();
    chk("t6_rst_rq", int_rq, 0);
    chk("t6_rst_addr", int_addr, 0);
    chk("t6_rst_rdata", cfg_rdata, 0);
    reset = 1'b0;
    rd_chk("t6_mask", 3'd0, 16'h0000);
    rd_chk("t6_mode", 3'd1, 16'h0000);
    rd_chk("t6_pend", 3'd2, 16'h0000);
    rd_chk("t6_status", 3'd3, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      if ($urandom_range(0, 5) == 0) irq_in[$urandom_range(0, 15)] ^= 1'b1;
      cfg_wren = 1'b0; cfg_ren = 1'b0;
      r = $urandom_range(0, 19);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_wdata = 16'($urandom);
      if (r < 3) begin
        cfg_wren = 1'b1;
        cfg_addr = 3'd4;
      end else if (r < 5) begin
        cfg_wren = 1'b1;
      end else if (r < 12) begin
        cfg_ren = 1'b1;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    cfg_wren = 1'b0; cfg_ren = 1'b0; reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
